// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HEADER_BYTES   = 4;
  localparam int CHECKSUM_BYTES = 4;

  // States in which the loader is consuming the frame
  function automatic logic is_active(input state_t s);
    return (s == HEADER) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian bytes into 32-bit words; word_valid fires combinationally
// with the 4th accepted byte so the caller can act on the completed word that cycle.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        flush,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx;
  logic [23:0] shift;

  // Completed word is the three stored bytes followed by the byte arriving now
  always_comb begin
    word       = {shift, data};
    word_valid = accept && (idx == LAST_IDX);
  end

  // Byte index and shift register; flush realigns to a word boundary
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (flush) begin
      idx   <= 2'd0;
      shift <= 24'd0;
    end else if (accept) begin
      idx   <= idx + 2'd1;
      shift <= {shift[15:0], data};
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Fills instruction memory from a framed byte stream (count, words, XOR checksum)
// and keeps the CPU held in clear until a frame loads with a matching checksum.
// Stream handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both 1; in_data is ignored otherwise and in_valid may drop at any time.
module instr_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 9
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_write,
  output logic [31:0]      imem_address,
  output logic [31:0]      imem_write_data,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded,
  output state_t           dbg_state
);

  state_t            state, next_state;
  logic              accept;
  logic              start_ok;
  logic [31:0]       word;
  logic              word_valid;
  logic [CNT_W-1:0]  n_words;
  logic [31:0]       acc;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign last_word = ((words_loaded + CNT_W'(1)) == n_words);
  assign dbg_state = state;

  byte_packer u_packer (
    .clock      (clock),
    .clear      (clear),
    .accept     (accept),
    .data       (in_data),
    .flush      (start_ok),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: each field completes on the 4th byte of its word
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = HEADER;
      HEADER: if (word_valid) begin
        if (word > 32'(MAX_WORDS)) next_state = ERROR;
        else if (word == 32'd0)    next_state = CHECK;
        else                       next_state = DATA;
      end
      DATA:  if (word_valid && last_word) next_state = CHECK;
      CHECK: if (word_valid) next_state = (word == acc) ? DONE : ERROR;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs registered from the upcoming state so they track state exactly
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= is_active(next_state);
      busy     <= is_active(next_state);
      cpu_hold <= (next_state != DONE);
      done     <= (next_state == DONE);
      error    <= (next_state == ERROR);
    end
  end

  // Word count latch, write port, word counter and checksum accumulator
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      n_words         <= '0;
      words_loaded    <= '0;
      acc             <= 32'd0;
      imem_write      <= 1'b0;
      imem_address    <= BASE_ADDR;
      imem_write_data <= 32'd0;
    end else begin
      imem_write <= 1'b0;
      if (start_ok) begin
        words_loaded <= '0;
        acc          <= 32'd0;
      end
      if ((state == HEADER) && word_valid) n_words <= word[CNT_W-1:0];
      if ((state == DATA) && word_valid) begin
        imem_write      <= 1'b1;
        imem_address    <= BASE_ADDR + (32'(words_loaded) << 2);
        imem_write_data <= word;
        words_loaded    <= words_loaded + CNT_W'(1);
        acc             <= acc ^ word;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized frames against a frame-level model of the loader.
module tb_instr_loader;
  import loader_pkg::*;

  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          MAX_WORDS = 256;
  localparam int          CNT_W     = 9;

  logic             clock = 1'b0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             imem_write;
  logic [31:0]      imem_address;
  logic [31:0]      imem_write_data;
  logic             cpu_hold;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] words_loaded;
  state_t           dbg_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [31:0] frame_words[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];

  instr_loader #(.BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .clear           (clear),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .imem_write      (imem_write),
    .imem_address    (imem_address),
    .imem_write_data (imem_write_data),
    .cpu_hold        (cpu_hold),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .words_loaded    (words_loaded),
    .dbg_state       (dbg_state)
  );

  // clock
  always #5 clock = ~clock;

  // write-port monitor, sampled mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (imem_write === 1'b1) begin
      obs_q.push_back({imem_address, imem_write_data});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one byte; called and returns on a falling edge
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clock);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    start = pulse_start;
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit pulse_start);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gaps, pulse_start && (i == 3));
  endtask

  task automatic pulse_start_only();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // full frame: model expectation from frame contents, then compare
  task automatic do_frame(input logic [31:0] n, input logic [31:0] chk, input bit gaps,
                          input bit mid_start, input string tag);
    logic [31:0] x;
    bit          ok;
    pulse_start_only();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    x = 32'd0;
    if (n <= 32'(MAX_WORDS)) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_q.push_back({BASE_ADDR + 32'(4 * i), frame_words[i]});
        x ^= frame_words[i];
      end
    end
    ok = (n <= 32'(MAX_WORDS)) && (chk == x);
    send_word(n, gaps, 1'b0);
    if (n <= 32'(MAX_WORDS)) begin
      for (int i = 0; i < int'(n); i++) send_word(frame_words[i], gaps, mid_start && (i == 0));
      send_word(chk, gaps, 1'b0);
    end
    repeat (3) @(negedge clock);
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_write"}, obs_q[i], exp_q[i]);
    if (!gaps && exp_q.size() >= 2 && obs_q.size() >= 2)
      check({tag, "_spacing"}, 64'(obs_cyc[1] - obs_cyc[0]), 64'd4);
    check({tag, "_done"},     {63'd0, done},     {63'd0, ok});
    check({tag, "_error"},    {63'd0, error},    {63'd0, !ok});
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !ok});
    check({tag, "_busy"},     {63'd0, busy},     64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_words"},    64'(words_loaded), (n <= 32'(MAX_WORDS)) ? 64'(n) : 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold},   64'd1);
    check({tag, "_in_ready"}, {63'd0, in_ready},   64'd0);
    check({tag, "_write"},    {63'd0, imem_write}, 64'd0);
    check({tag, "_done"},     {63'd0, done},       64'd0);
    check({tag, "_error"},    {63'd0, error},      64'd0);
    check({tag, "_busy"},     {63'd0, busy},       64'd0);
    check({tag, "_addr"},     64'(imem_address),   64'(BASE_ADDR));
    check({tag, "_words"},    64'(words_loaded),   64'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] x;

    // reset
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    clear = 1'b1;
    @(negedge clock);

    // two-word frame, good checksum, gap-free
    frame_words = '{32'h20080005, 32'h2009000A};
    do_frame(32'd2, 32'h0001000F, 1'b0, 1'b0, "two_good");

    // same frame, wrong checksum
    do_frame(32'd2, 32'h00000000, 1'b0, 1'b0, "two_bad");

    // count one beyond capacity
    frame_words.delete();
    do_frame(32'(MAX_WORDS + 1), 32'd0, 1'b0, 1'b0, "over_max");

    // empty frame
    do_frame(32'd0, 32'd0, 1'b0, 1'b0, "empty");

    // one word with random gaps and a start pulse inside DATA
    frame_words = '{32'($urandom)};
    do_frame(32'd1, frame_words[0], 1'b1, 1'b1, "one_gaps");

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      frame_words.delete();
      n = $urandom_range(1, 8);
      x = 32'd0;
      for (int i = 0; i < n; i++) begin
        frame_words.push_back(32'($urandom));
        x ^= frame_words[i];
      end
      if ($urandom_range(0, 3) == 0) x ^= 32'(1 << $urandom_range(0, 31));
      do_frame(32'(n), x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    // largest accepted frame
    frame_words.delete();
    x = 32'd0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      frame_words.push_back(32'($urandom));
      x ^= frame_words[i];
    end
    do_frame(32'(MAX_WORDS), x, 1'b0, 1'b0, "max");

    // reset in the middle of the second word
    frame_words = '{32'h11112222, 32'h33334444};
    pulse_start_only();
    obs_q.delete();
    obs_cyc.delete();
    send_word(32'd2, 1'b0, 1'b0);
    send_word(frame_words[0], 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    check("midrst_pre_writes", 64'(obs_q.size()), 64'd1);
    clear = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    frame_words = '{32'(($urandom)), 32'(($urandom)), 32'(($urandom))};
    do_frame(32'd3, frame_words[0] ^ frame_words[1] ^ frame_words[2], 1'b0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
